uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver (IDLE/START/DATA/PARITY/STOP) with parity and stop checks.
// Optional macro UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 majority vote around each bit centre.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic [2:0]            fsm_state_o
);

   // Handshake: data_valid is a one-cycle strobe with no ready; P_DATA must be taken in that cycle.
   // RX_IN is expected to be synchronised to CLK upstream.
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [2:0]            state_q, state_d;
   logic [5:0]            edge_q, edge_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [5:0]            pre_q, pre_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_flag_q, par_flag_d;
   logic                  stp_flag_q, stp_flag_d;
   logic                  rx_prev_q;
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  valid_q, valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic [5:0] half_pt, dec_pt, last_edge;
   logic       bit_val, at_dec, at_last;

   function automatic logic [5:0] decode_pre(input logic [5:0] p);
      case (p)
         6'd16:   return 6'd16;
         6'd32:   return 6'd32;
         default: return 6'd8;
      endcase
   endfunction

   assign half_pt   = {1'b0, pre_q[5:1]};
   assign last_edge = pre_q - 6'd1;

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] vote_q;

   // vote_q holds the samples from the two previous edges, so the decision lands one edge past centre.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) vote_q <= 2'b11;
      else      vote_q <= {vote_q[0], RX_IN};
   end

   assign dec_pt  = half_pt + 6'd1;
   assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & RX_IN) | (vote_q[0] & RX_IN);
`else
   assign dec_pt  = half_pt;
   assign bit_val = RX_IN;
`endif

   assign at_dec  = (edge_q == dec_pt);
   assign at_last = (edge_q == last_edge);

   always_comb begin
      state_d    = state_q;
      edge_d     = edge_q;
      bit_d      = bit_q;
      pre_d      = pre_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      shift_d    = shift_q;
      par_flag_d = par_flag_q;
      stp_flag_d = stp_flag_q;
      pdata_d    = pdata_q;
      valid_d    = 1'b0;
      par_err_d  = par_err_q;
      stp_err_d  = stp_err_q;
      case (state_q)
         IDLE: begin
            // A start needs a genuine falling edge, so a line held low across reset is ignored.
            if (!RX_IN && rx_prev_q) begin
               state_d    = START;
               edge_d     = 6'd0;
               bit_d      = '0;
               pre_d      = decode_pre(Prescale);
               par_en_d   = PAR_EN;
               par_typ_d  = PAR_TYP;
               par_flag_d = 1'b0;
               stp_flag_d = 1'b0;
            end
         end
         START: begin
            edge_d = edge_q + 6'd1;
            if (at_dec && bit_val) begin
               state_d = IDLE;
               edge_d  = 6'd0;
            end else if (at_last) begin
               state_d = DATA;
               edge_d  = 6'd0;
            end
         end
         DATA: begin
            edge_d = edge_q + 6'd1;
            if (at_dec) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
            if (at_last) begin
               edge_d = 6'd0;
               if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         PARITY: begin
            edge_d = edge_q + 6'd1;
            if (at_dec) par_flag_d = bit_val ^ (^shift_q) ^ par_typ_q;
            if (at_last) begin
               state_d = STOP;
               edge_d  = 6'd0;
            end
         end
         STOP: begin
            edge_d = edge_q + 6'd1;
            if (at_dec) stp_flag_d = ~bit_val;
            // Leave half a bit early so a following start edge is never missed.
            if (edge_q == dec_pt + 6'd1) begin
               state_d   = IDLE;
               edge_d    = 6'd0;
               par_err_d = par_flag_q;
               stp_err_d = stp_flag_q;
               if (!par_flag_q && !stp_flag_q) begin
                  pdata_d = shift_q;
                  valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            edge_d  = 6'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         edge_q     <= 6'd0;
         bit_q      <= '0;
         pre_q      <= 6'd8;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         shift_q    <= '0;
         par_flag_q <= 1'b0;
         stp_flag_q <= 1'b0;
         rx_prev_q  <= 1'b0;
         pdata_q    <= '0;
         valid_q    <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         edge_q     <= edge_d;
         bit_q      <= bit_d;
         pre_q      <= pre_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         shift_q    <= shift_d;
         par_flag_q <= par_flag_d;
         stp_flag_q <= stp_flag_d;
         rx_prev_q  <= RX_IN;
         pdata_q    <= pdata_d;
         valid_q    <= valid_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
      end
   end

   assign P_DATA      = pdata_q;
   assign data_valid  = valid_q;
   assign par_err     = par_err_q;
   assign stp_err     = stp_err_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: frame-level driver, queue scoreboard fed at stimulus time, passive monitor.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic [2:0] fsm_state;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] mdl_data = 8'h00;
   logic       mdl_par = 1'b0;
   logic       mdl_stp = 1'b0;
   logic       prev_valid = 1'b0;

   uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
      .stp_err(stp_err), .fsm_state_o(fsm_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff_pre(input logic [5:0] p);
      if (p == 6'd16) return 16;
      if (p == 6'd32) return 32;
      return 8;
   endfunction

   // driver: one frame, bit period from the oversampling ratio, settings scrambled after the start bit
   task automatic send_frame(input logic [7:0] d, input logic [5:0] pre_in, input logic pen,
                             input logic ptyp, input logic bad_par, input logic stop_bit,
                             input int abort_bit, input int glitch_bit);
      int   p;
      logic par;
      logic bits[$];
      p   = eff_pre(pre_in);
      par = (($countones(d) % 2) == 1) ^ ptyp ^ bad_par;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(par);
      bits.push_back(stop_bit);
      if (abort_bit < 0) begin
         mdl_par = pen && bad_par;
         mdl_stp = !stop_bit;
         if (!mdl_par && !mdl_stp) begin
            exp_q.push_back(d);
            mdl_data = d;
         end
      end
      Prescale = pre_in;
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      foreach (bits[i]) begin
         if (i == 1) begin
            Prescale = 6'($urandom_range(0, 63));
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
         end
         RX_IN = bits[i];
         if (abort_bit >= 0 && i == abort_bit + 1) begin
            repeat (p / 2) @(negedge CLK);
            return;
         end
         if (glitch_bit >= 0 && i == glitch_bit + 1) begin
            repeat (p / 2 + 1) @(negedge CLK);
            RX_IN = ~bits[i];
            @(negedge CLK);
            RX_IN = bits[i];
            repeat (p - p / 2 - 2) @(negedge CLK);
         end else begin
            repeat (p) @(negedge CLK);
         end
      end
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_par_err"}, {31'd0, par_err}, {31'd0, mdl_par});
      check({tag, "_stp_err"}, {31'd0, stp_err}, {31'd0, mdl_stp});
      check({tag, "_p_data"}, {24'd0, P_DATA}, {24'd0, mdl_data});
   endtask

   task automatic idle_bits(input int n, input int p);
      RX_IN = 1'b1;
      repeat (n * p) @(negedge CLK);
   endtask

   // monitor / scoreboard
   always @(negedge CLK) begin
      logic [7:0] e;
      if (data_valid) begin
         check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got P_DATA=%0h expected no pulse at %0t", P_DATA, $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_p_data", {24'd0, P_DATA}, {24'd0, e});
         end
      end
      prev_valid = data_valid;
   end

   initial begin
      logic [5:0] pre_tbl[10];
      pre_tbl = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd5, 6'd0, 6'd63, 6'd24};

      repeat (3) @(negedge CLK);
      check("rst_p_data", {24'd0, P_DATA}, 32'd0);
      check("rst_valid", {31'd0, data_valid}, 32'd0);
      check("rst_par_err", {31'd0, par_err}, 32'd0);
      check("rst_stp_err", {31'd0, stp_err}, 32'd0);
      RST = 1'b1;
      idle_bits(2, 8);

      send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      check_frame("a5_p8");
      idle_bits(1, 8);

      send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
      check_frame("3c_par_ok");
      idle_bits(1, 16);
      send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
      check_frame("3c_par_bad");
      idle_bits(1, 16);

      send_frame(8'h55, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      check_frame("55_stop_bad");
      idle_bits(1, 32);

      // two-cycle low glitch must be rejected in START
      Prescale = 6'd16;
      RX_IN    = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (40) @(negedge CLK);
      check_frame("glitch16");

      send_frame(8'h01, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      check_frame("b2b");
      send_frame(8'h10, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      check_frame("10_par_bad");

      // reset in the middle of data bit 4 while the line is low
      send_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1);
      RST = 1'b0;
      #1;
      mdl_data = 8'h00;
      mdl_par  = 1'b0;
      mdl_stp  = 1'b0;
      check("midrst_p_data", {24'd0, P_DATA}, 32'd0);
      check("midrst_valid", {31'd0, data_valid}, 32'd0);
      check("midrst_par_err", {31'd0, par_err}, 32'd0);
      check("midrst_stp_err", {31'd0, stp_err}, 32'd0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (24) @(negedge CLK);
      idle_bits(2, 8);
      send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      check_frame("81_after_rst");
      idle_bits(1, 8);

`ifdef UART_RX_MAJORITY_VOTE_EN
      send_frame(8'h5A, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);
      check_frame("vote_glitch");
      idle_bits(1, 16);
`endif

      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         logic [5:0] pr;
         logic       pen, ptyp, bpar, sbit;
         d    = 8'($urandom_range(0, 255));
         pr   = pre_tbl[$urandom_range(0, 9)];
         pen  = 1'($urandom_range(0, 1));
         ptyp = 1'($urandom_range(0, 1));
         bpar = pen && ($urandom_range(0, 4) == 0);
         sbit = ($urandom_range(0, 5) != 0);
         send_frame(d, pr, pen, ptyp, bpar, sbit, -1, -1);
         check_frame("rand");
         if (!sbit || $urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 2), eff_pre(pr));
      end

      idle_bits(4, 8);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
